key_press_classifier: RTL
=========================

KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 50_000_000, giving the hold time in clk cycles that classifies a press as long (1 s at 50 MHz).
REQ-002 The block SHALL have parameter DCLICK_CYCLES, default 15_000_000, giving the window in clk cycles after a release in which a second press forms a double click.
REQ-003 The block SHALL have parameter REPEAT_CYCLES, default 10_000_000, giving the auto-repeat period in clk cycles.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 key_down  input  1  one-cycle debounced press pulse from the key debouncer.
REQ-007 key_up  input  1  one-cycle debounced release pulse from the key debouncer.
REQ-008 short_press  output  1  one-cycle pulse marking a single short press.
REQ-009 long_press  output  1  one-cycle pulse marking a long press.
REQ-010 double_click  output  1  one-cycle pulse marking a double click.
REQ-011 repeat_tick  output  1  one-cycle auto-repeat pulse while a long press is held.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 event_cnt  output  8  count of classified events (short, long and double).

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, HELD, WAIT2, HELD2 and LONG.
REQ-015 A single 32-bit counter cnt SHALL be cleared on every state transition and SHALL increment by 1 in all other cycles while in HELD, WAIT2 or LONG.
REQ-016 IDLE: on key_down the FSM SHALL move to HELD; key_up SHALL be ignored.
REQ-017 HELD: on key_up the FSM SHALL move to WAIT2; otherwise, when cnt == LONG_CYCLES-1, it SHALL pulse long_press and move to LONG.
REQ-018 WAIT2: on key_down the FSM SHALL move to HELD2; otherwise, when cnt == DCLICK_CYCLES-1, it SHALL pulse short_press and move to IDLE.
REQ-019 HELD2: on key_up the FSM SHALL pulse double_click and move to IDLE; HELD2 SHALL have no timeout.
REQ-020 LONG: on key_up the FSM SHALL move to IDLE with no classification pulse.
REQ-021 key_down SHALL be ignored in HELD, HELD2 and LONG.
REQ-022 If key_down and key_up are asserted in the same cycle, only key_up SHALL be acted on.
REQ-023 If key_up and a cnt terminal value coincide in a cycle, key_up SHALL take priority.
REQ-024 All outputs SHALL be registered; each pulse SHALL be high for exactly the one cycle after the deciding input or terminal-count cycle.
REQ-025 short_press, long_press and double_click SHALL be mutually exclusive in every cycle.
REQ-026 event_cnt SHALL increment by 1 in the cycle any classification pulse is asserted, and SHALL wrap from 255 to 0.

Reset
REQ-027 While rst is high at a clk edge, the state SHALL be set to IDLE and cnt and event_cnt SHALL be cleared to 0.
REQ-028 While rst is high at a clk edge, short_press, long_press, double_click, repeat_tick and busy SHALL be cleared to 0.
REQ-029 Reset asserted mid-press SHALL discard the press; a key_up after reset release SHALL be ignored in IDLE.

Configuration
REQ-030 With macro KEY_REPEAT_EN defined, in LONG a separate 32-bit repeat counter SHALL pulse repeat_tick every REPEAT_CYCLES cycles.
REQ-031 With KEY_REPEAT_EN defined, the first repeat_tick SHALL occur REPEAT_CYCLES cycles after long_press, and the repeat counter SHALL stop and clear on leaving LONG.
REQ-032 With KEY_REPEAT_EN defined, repeat_tick SHALL NOT change event_cnt.
REQ-033 Without KEY_REPEAT_EN, repeat_tick SHALL be constant 0, no repeat counter logic SHALL exist, and the port SHALL still be present.

Verification (LONG_CYCLES=20, DCLICK_CYCLES=10, REPEAT_CYCLES=5)
REQ-034 Short: key_down at t0, key_up at t5 -> short_press at t16, event_cnt=1, busy low from t16.
REQ-035 Long: key_down at t0, key_up at t40 -> long_press at t21 only, no other pulse; with KEY_REPEAT_EN, repeat_tick at t26, t31, t36.
REQ-036 Double: down t0, up t3, down t8, up t12 -> double_click at t13; no short_press; event_cnt=1.
REQ-037 Boundary: key_up at the cycle cnt==19 in HELD -> WAIT2 entered, no long_press; key_down and key_up in the same IDLE cycle -> stays IDLE.
REQ-038 Reset: rst pulse in WAIT2 -> IDLE with all outputs 0 and no short_press; 256 short presses -> event_cnt wraps to 0.

Source files
------------

// File: rtl/key_press_classifier.sv
// Classifies debounced key press/release pulses into short press, long press and double click.
// Optional auto-repeat while a long press is held is built when KEY_REPEAT_EN is defined.
module key_press_classifier #(
    parameter int unsigned LONG_CYCLES   = 32'd50_000_000,
    parameter int unsigned DCLICK_CYCLES = 32'd15_000_000,
    parameter int unsigned REPEAT_CYCLES = 32'd10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_down,
    input  logic       key_up,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       repeat_tick,
    output logic       busy,
    output logic [7:0] event_cnt
);

    localparam logic [31:0] LONG_TERM   = 32'(LONG_CYCLES - 32'd1);
    localparam logic [31:0] DCLICK_TERM = 32'(DCLICK_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD  = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] cnt_r;
    logic        short_s;
    logic        long_s;
    logic        double_s;
    logic        press_s;

    // A press coinciding with a release is dropped: the release wins.
    assign press_s = key_down & ~key_up;

    // Next-state decode and classification decisions.
    always_comb begin
        next_state_s = state_r;
        short_s      = 1'b0;
        long_s       = 1'b0;
        double_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (press_s) begin
                    next_state_s = HELD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HELD: begin
                if (key_up) begin
                    next_state_s = WAIT2;
                end else if (cnt_r == LONG_TERM) begin
                    next_state_s = LONG;
                    long_s       = 1'b1;
                end else begin
                    next_state_s = HELD;
                end
            end
            WAIT2: begin
                if (press_s) begin
                    next_state_s = HELD2;
                end else if (cnt_r == DCLICK_TERM) begin
                    next_state_s = IDLE;
                    short_s      = 1'b1;
                end else begin
                    next_state_s = WAIT2;
                end
            end
            HELD2: begin
                if (key_up) begin
                    next_state_s = IDLE;
                    double_s     = 1'b1;
                end else begin
                    next_state_s = HELD2;
                end
            end
            LONG: begin
                if (key_up) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = LONG;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register and the shared dwell counter, cleared on every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                cnt_r <= 32'd0;
            end else if ((state_r == HELD) || (state_r == WAIT2) || (state_r == LONG)) begin
                cnt_r <= cnt_r + 32'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered classification pulses, busy flag and event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
            event_cnt    <= 8'd0;
        end else begin
            short_press  <= short_s;
            long_press   <= long_s;
            double_click <= double_s;
            busy         <= (next_state_s != IDLE);
            if (short_s || long_s || double_s) begin
                event_cnt <= event_cnt + 8'd1;
            end else begin
                event_cnt <= event_cnt;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [31:0] REPEAT_TERM = 32'(REPEAT_CYCLES - 32'd1);

    logic [31:0] rep_cnt_r;

    // Auto-repeat timer: runs only while LONG is held, a release suppresses a pending tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_r   <= 32'd0;
            repeat_tick <= 1'b0;
        end else if ((state_r == LONG) && (next_state_s == LONG)) begin
            if (rep_cnt_r == REPEAT_TERM) begin
                rep_cnt_r   <= 32'd0;
                repeat_tick <= 1'b1;
            end else begin
                rep_cnt_r   <= rep_cnt_r + 32'd1;
                repeat_tick <= 1'b0;
            end
        end else begin
            rep_cnt_r   <= 32'd0;
            repeat_tick <= 1'b0;
        end
    end
`else
    assign repeat_tick = 1'b0;
`endif

endmodule
